// File: rtl/seg_pkg.sv
// Shared types for the BCD converter and the seven-segment scanner.
// Holds the FSM state enum, digit count, the 9999 limit and the BCD nibble type.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int SEG_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction.
// Adds 3 to a BCD nibble that is 5 or more, so the next left shift carries into the next digit.
module bcd_adj3
    import seg_pkg::*;
(
    input  bcd_t din,
    output bcd_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble bit per clock.
// The registered digits are replaced only on the done edge, so the display never shows partial results.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = SEG_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    localparam int SCR_W = DIGITS * 4 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(BCD_MAX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    bcd_t               nib_in  [DIGITS];
    bcd_t               nib_out [DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign nib_in[i] = scratch[BIN_W+4*i +: 4];
        bcd_adj3 u_adj (
            .din  (nib_in[i]),
            .dout (nib_out[i])
        );
    end

    // Only the BCD field is corrected; the binary field below it just shifts.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            adj[BIN_W+4*i +: 4] = nib_out[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd3     <= 4'h0;
            bcd2     <= 4'h0;
            bcd1     <= 4'h0;
            bcd0     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        scratch  <= {{(DIGITS*4){1'b0}}, bin};
                        cnt      <= '0;
                        ovf_pend <= (bin > BIN_MAX);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= adj << 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd3  <= ovf_pend ? 4'h9 : scratch[BIN_W+12 +: 4];
                    bcd2  <= ovf_pend ? 4'h9 : scratch[BIN_W+8 +: 4];
                    bcd1  <= ovf_pend ? 4'h9 : scratch[BIN_W+4 +: 4];
                    bcd0  <= ovf_pend ? 4'h9 : scratch[BIN_W +: 4];
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq.
// A decimal-arithmetic model predicts busy/done/ovf/digits on every cycle.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, ovf;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd3  (bcd3),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model: ph counts edges since acceptance (0 = idle).
    int          ph = 0;
    int          m_val = 0;
    logic        m_busy = 0, m_done = 0, m_ovf = 0;
    logic [15:0] m_bcd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_bcd = '0;
        end else begin
            m_done = 0;
            if (ph == 0) begin
                if (start) begin
                    m_val = int'(bin);
                    ph = 1;
                end
            end else if (ph < 15) begin
                ph = ph + 1;
            end else begin
                ph = 0;
                m_done = 1;
                m_bcd = to_bcd(m_val);
                m_ovf = (m_val > 9999);
            end
            m_busy = (ph >= 1 && ph <= 14);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cycle", {13'b0, busy, done, ovf, bcd3, bcd2, bcd1, bcd0},
              {13'b0, m_busy, m_done, m_ovf, m_bcd});
    end

    // Pulse start with v, wait (bounded) for done, return latency and busy cycles.
    task automatic run_conv(input logic [13:0] v, output int lat, output int bcyc, output bit ok);
        lat = 0; bcyc = 0; ok = 0;
        @(negedge clk);
        start = 1'b1;
        bin = v;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            bin = 14'($urandom_range(0, 16383));
            lat++;
            if (busy) bcyc++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic directed(input string name, input logic [13:0] v,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat, bcyc;
        bit ok;
        run_conv(v, lat, bcyc, ok);
        check({name, "_dut"}, {15'b0, ovf, bcd3, bcd2, bcd1, bcd0}, {15'b0, exp_ovf, exp_bcd});
        check({name, "_model"}, {15'b0, m_ovf, m_bcd}, {15'b0, exp_ovf, exp_bcd});
    endtask

    initial begin
        int lat, bcyc, dones;
        bit ok, seen;
        logic [13:0] v;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {19'b0, busy, done, ovf, bcd3, bcd2, bcd1, bcd0}, 32'd0);
        rst_n = 1'b1;

        run_conv(14'd0, lat, bcyc, ok);
        check("lat_zero", lat, 32'd16);
        check("busy_cycles", bcyc, 32'd14);
        check("zero_dut", {15'b0, ovf, bcd3, bcd2, bcd1, bcd0}, 32'h0);

        directed("v1234", 14'd1234, 16'h1234, 1'b0);
        directed("v9999", 14'd9999, 16'h9999, 1'b0);
        directed("v12000", 14'd12000, 16'h9999, 1'b1);
        directed("v42", 14'd42, 16'h0042, 1'b0);
        directed("v16383", 14'd16383, 16'h9999, 1'b1);
        directed("v10000", 14'd10000, 16'h9999, 1'b1);

        for (int k = 0; k < 10; k++) begin
            v = 14'($urandom_range(0, 16383));
            run_conv(v, lat, bcyc, ok);
            check("rand_dut", {15'b0, ovf, bcd3, bcd2, bcd1, bcd0},
                  {15'b0, (int'(v) > 9999), to_bcd(int'(v))});
        end

        // start held high: accepts every 16 cycles
        @(negedge clk);
        repeat (4) @(negedge clk);
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            bin = 14'($urandom_range(0, 16383));
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        check("held_start_dones", dones, 32'd5);
        repeat (20) @(negedge clk);

        directed("v7", 14'd7, 16'h0007, 1'b0);
        @(negedge clk);
        start = 1'b1;
        bin = 14'd65;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_state", {19'b0, busy, done, ovf, bcd3, bcd2, bcd1, bcd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("no_done_after_abort", {31'b0, seen}, 32'd0);
        directed("v65", 14'd65, 16'h0065, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
